// File: rtl/aura_o_writeback.sv
// aura_o_writeback: buffers finished output words and stores them to the O region.
// Optional feature: define AURA_WB_CHECKSUM_EN to build the running XOR checksum of accepted stores.
module aura_o_writeback #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,  // O_BASE
  parameter int unsigned NUM_WORDS  = 512,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned MEM_BLOCK_W = 64,
  localparam int unsigned ADDR_W      = 32,
  localparam int unsigned TAG_W       = 4,
  localparam int unsigned CMD_W       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [MEM_BLOCK_W-1:0] in_data,
  output logic                   in_ready,
  input  logic                   mem_grant,
  input  logic [TAG_W-1:0]       mem2proc_transaction_tag,
  output logic [CMD_W-1:0]       proc2mem_command,
  output logic [ADDR_W-1:0]      proc2mem_addr,
  output logic [MEM_BLOCK_W-1:0] proc2mem_data,
  output logic                   done,
  output logic [MEM_BLOCK_W-1:0] checksum
);

  localparam logic [CMD_W-1:0] MEM_NONE  = 2'd0;
  localparam logic [CMD_W-1:0] MEM_STORE = 2'd2;

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic {
    S_RUN = 1'b0,
    S_FIN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [MEM_BLOCK_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]       occ_q;
  logic [CNT_W-1:0]       in_cnt_q, wr_cnt_q;

  logic full, empty, push, pop;

  assign full  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign empty = (occ_q == '0);

  // Store address and data come straight from registered state, so they hold while a store is retried.
  assign proc2mem_addr = BASE_ADDR + (ADDR_W'(wr_cnt_q) << 3);
  assign proc2mem_data = empty ? '0 : fifo_q[rd_ptr_q];

  // Next-state and handshake decode; FIN shuts off both the input side and the bus.
  always_comb begin
    state_d          = state_q;
    in_ready         = 1'b0;
    proc2mem_command = MEM_NONE;
    done             = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    case (state_q)
      S_RUN: begin
        in_ready = !full && (in_cnt_q < CNT_W'(NUM_WORDS));
        if (mem_grant && !empty) begin
          proc2mem_command = MEM_STORE;
        end
        push = in_valid && in_ready;
        pop  = (proc2mem_command == MEM_STORE) && (mem2proc_transaction_tag != '0);
        if (pop && (wr_cnt_q == CNT_W'(NUM_WORDS - 1))) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Word counters; pushes are gated by in_cnt and pops by occupancy, so both stop at NUM_WORDS.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (push && (in_cnt_q != CNT_W'(NUM_WORDS))) begin
        in_cnt_q <= in_cnt_q + CNT_W'(1);
      end
      if (pop && (wr_cnt_q != CNT_W'(NUM_WORDS))) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef AURA_WB_CHECKSUM_EN
  logic [MEM_BLOCK_W-1:0] csum_q;

  // Signature of everything committed to memory since reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ proc2mem_data;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_aura_o_writeback.sv
// Bench for aura_o_writeback: queue-based reference model plus directed literal checks.
module tb_aura_o_writeback;

  localparam logic [1:0]  C_NONE  = 2'd0;
  localparam logic [1:0]  C_STORE = 2'd2;
  localparam logic [31:0] O_BASE  = 32'h0000_3000;
  localparam int          NW      = 512;
  localparam int          DEPTH   = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // main instance (default sizing)
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        mem_grant = 1'b0;
  logic [3:0]  tag = '0;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        done;
  logic [63:0] csum;

  // single-word instance
  logic        s_reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_ready;
  logic        s_grant = 1'b0;
  logic [3:0]  s_tag = '0;
  logic [1:0]  s_cmd;
  logic [31:0] s_addr;
  logic [63:0] s_wdata;
  logic        s_done;
  logic [63:0] s_csum;

  aura_o_writeback #(.BASE_ADDR(O_BASE)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_grant(mem_grant), .mem2proc_transaction_tag(tag), .proc2mem_command(cmd),
    .proc2mem_addr(addr), .proc2mem_data(wdata), .done(done), .checksum(csum)
  );

  aura_o_writeback #(.BASE_ADDR(32'h0000_1000), .NUM_WORDS(1)) u_single (
    .clock(clock), .reset(s_reset), .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
    .mem_grant(s_grant), .mem2proc_transaction_tag(s_tag), .proc2mem_command(s_cmd),
    .proc2mem_addr(s_addr), .proc2mem_data(s_wdata), .done(s_done), .checksum(s_csum)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] wgen(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i)};
  endfunction

  // Reference model: words waiting to be stored, counts, done flag, signature, observed memory.
  logic [63:0] mq[$];
  int          m_pushed = 0;
  int          m_stored = 0;
  bit          m_done = 1'b0;
  bit          m_valid = 1'b0;
  logic [63:0] m_csum = '0;
  logic [63:0] omem [logic [31:0]];
  int          st_seen = 0;

  bit          e_ready;
  logic [1:0]  e_cmd;
  logic [31:0] e_addr;
  logic [63:0] e_data;
  logic [63:0] e_csum;

  // Compare every cycle on the falling edge, then advance the model to the next rising edge.
  always @(negedge clock) begin
    if (m_valid) begin
      e_ready = !m_done && (mq.size() < DEPTH) && (m_pushed < NW);
      e_cmd   = (!m_done && mem_grant && (mq.size() > 0)) ? C_STORE : C_NONE;
      e_addr  = O_BASE + 32'(m_stored * 8);
      e_data  = (mq.size() > 0) ? mq[0] : 64'h0;
`ifdef AURA_WB_CHECKSUM_EN
      e_csum  = m_csum;
`else
      e_csum  = 64'h0;
`endif
      chk("m_in_ready", 64'(in_ready), 64'(e_ready));
      chk("m_command",  64'(cmd),      64'(e_cmd));
      chk("m_addr",     64'(addr),     64'(e_addr));
      chk("m_data",     wdata,         e_data);
      chk("m_done",     64'(done),     64'(m_done));
      chk("m_checksum", csum,          e_csum);
      if (cmd == C_STORE && tag != 4'd0) begin
        omem[addr] = wdata;
        st_seen++;
      end
    end
    if (reset) begin
      mq.delete();
      m_pushed = 0;
      m_stored = 0;
      m_done   = 1'b0;
      m_csum   = '0;
      st_seen  = 0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      if (e_cmd == C_STORE && tag != 4'd0) begin
        m_csum = m_csum ^ mq[0];
        void'(mq.pop_front());
        m_stored++;
        if (m_stored == NW) m_done = 1'b1;
      end
      if (in_valid && e_ready) begin
        mq.push_back(in_data);
        m_pushed++;
      end
    end
  end

  int  idx = 0;
  bit  fire;
  bit  seen;

  // One cycle of input driving: advance the data source only when the word was taken.
  task automatic step();
    fire = in_valid && in_ready;
    @(posedge clock); #1;
    if (fire) begin
      idx++;
      in_data = wgen(idx);
    end
  endtask

  logic [63:0] exp_s_csum;

  initial begin
    in_data = wgen(0);

    // single-word run
    repeat (2) @(posedge clock);
    #1;
    s_reset = 1'b0; s_valid = 1'b1; s_data = 64'hDEAD_BEEF_0000_0001; s_grant = 1'b1; s_tag = 4'd1;
    @(negedge clock);
    chk("single_ready_reset", 64'(s_ready), 64'd1);
    chk("single_cmd_reset",   64'(s_cmd),   64'(C_NONE));
    @(posedge clock); #1;
    s_valid = 1'b0;
    @(negedge clock);
    chk("single_cmd",  64'(s_cmd),  64'(C_STORE));
    chk("single_addr", 64'(s_addr), 64'h1000);
    chk("single_data", s_wdata,     64'hDEAD_BEEF_0000_0001);
    chk("single_done_early", 64'(s_done), 64'd0);
    @(negedge clock);
    chk("single_done",    64'(s_done),  64'd1);
    chk("single_cmd_fin", 64'(s_cmd),   64'(C_NONE));
    chk("single_ready_fin", 64'(s_ready), 64'd0);
`ifdef AURA_WB_CHECKSUM_EN
    exp_s_csum = 64'hDEAD_BEEF_0000_0001;
`else
    exp_s_csum = 64'h0;
`endif
    chk("single_checksum", s_csum, exp_s_csum);
    @(negedge clock);
    chk("single_done_sticky", 64'(s_done), 64'd1);

    // main instance out of reset
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cmd",      64'(cmd),      64'(C_NONE));
    chk("rst_addr",     64'(addr),     64'(O_BASE));
    chk("rst_data",     wdata,         64'h0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_checksum", csum,          64'h0);

    // backpressure: no grant, FIFO fills to its depth
    @(posedge clock); #1;
    in_valid = 1'b1;
    repeat (12) step();
    @(negedge clock);
    chk("bp_pushed",   64'(idx),      64'd8);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_cmd",      64'(cmd),      64'(C_NONE));
    @(posedge clock); #1;
    in_valid = 1'b0; mem_grant = 1'b1; tag = 4'd1;
    @(negedge clock);
    chk("drain_cmd",  64'(cmd),  64'(C_STORE));
    chk("drain_addr", 64'(addr), 64'(O_BASE));
    chk("drain_data", wdata,     wgen(0));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (cmd == C_NONE) begin
        seen = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 64'(seen), 64'd1);
    chk("drain_addr_end", 64'(addr), 64'(O_BASE + 32'h40));

    // retry: three zero-tag granted cycles, then tag 2
    @(posedge clock); #1;
    mem_grant = 1'b0; tag = 4'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mem_grant = 1'b1; tag = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("retry_cmd",  64'(cmd),  64'(C_STORE));
      chk("retry_addr", 64'(addr), 64'(O_BASE + 32'h40));
      chk("retry_data", wdata,     wgen(8));
      @(posedge clock); #1;
    end
    tag = 4'd2;
    @(negedge clock);
    chk("retry_final_addr", 64'(addr), 64'(O_BASE + 32'h40));
    chk("retry_final_data", wdata,     wgen(8));
    @(posedge clock); #1;
    tag = 4'd1;
    @(negedge clock);
    chk("retry_after_cmd",  64'(cmd),  64'(C_NONE));
    chk("retry_after_addr", 64'(addr), 64'(O_BASE + 32'h48));

    // streaming to the end of the region, then overflow attempts
    @(posedge clock); #1;
    in_valid = 1'b1; mem_grant = 1'b1; tag = 4'd1;
    for (int k = 0; k < 2000; k++) begin
      if (idx == NW) break;
      step();
    end
    chk("stream_pushed", 64'(idx), 64'(NW));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_timeout", 64'(seen), 64'd1);
    @(posedge clock); #1;
    repeat (5) step();
    @(negedge clock);
    chk("ovf_pushed",   64'(idx),      64'(NW));
    chk("ovf_in_ready", 64'(in_ready), 64'd0);
    chk("ovf_cmd",      64'(cmd),      64'(C_NONE));
    chk("ovf_done",     64'(done),     64'd1);
    chk("ovf_addr",     64'(addr),     64'h0000_4000);
    chk("store_count",  64'(st_seen),  64'(NW));
    for (int i = 0; i < NW; i++) begin
      if (omem.exists(O_BASE + 32'(i * 8))) chk("mem_word", omem[O_BASE + 32'(i * 8)], wgen(i));
      else chk("mem_word_missing", 64'h0, 64'h1);
    end

    // mid-run reset after 100 stores
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; idx = 0; in_data = wgen(0); in_valid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (idx == 100) break;
      step();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (st_seen >= 100) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_stores", 64'(seen), 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; mem_grant = 1'b0;
    @(negedge clock);
    chk("mid_done",     64'(done),     64'd0);
    chk("mid_checksum", csum,          64'h0);
    chk("mid_addr",     64'(addr),     64'(O_BASE));
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_data = 64'h5555_AAAA_0000_0064; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mem_grant = 1'b1;
    @(negedge clock);
    chk("mid_next_cmd",  64'(cmd),  64'(C_STORE));
    chk("mid_next_addr", 64'(addr), 64'(O_BASE));
    chk("mid_next_data", wdata,     64'h5555_AAAA_0000_0064);
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/aura_o_writeback.md
# aura_o_writeback

Output write-back engine for the AURA FlashAttention accelerator. It accepts finished 64-bit output words from the attention datapath, buffers them in a small FIFO, and issues `MEM_STORE` transactions on the proc2mem bus to consecutive addresses starting at the O base. It raises a sticky `done` once the full output region has been committed to memory. It is the writer of the O region that the testbench reads back after `done`, and it shares the memory port with the Q/K/V loaders through an external grant.

## Interface
Parameters:
- `BASE_ADDR`, default `O_BASE`: byte address of the first output word.
- `NUM_WORDS`, default 512: 64-bit words per run, i.e. one O region.
- `FIFO_DEPTH`, default 8: buffer entries; must be a power of 2 and ≥ 2.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: datapath presents an output word.
- `in_data`  in  `MEM_BLOCK` (64): output word.
- `in_ready`  out  1: word accepted at the rising edge where `in_valid && in_ready`.
- `mem_grant`  in  1: arbiter grants the memory port this cycle.
- `mem2proc_transaction_tag`  in  `MEM_TAG`: nonzero means the presented command is accepted.
- `proc2mem_command`  out  `MEM_COMMAND`: `MEM_STORE` or `MEM_NONE`.
- `proc2mem_addr`  out  `ADDR` (32): store address.
- `proc2mem_data`  out  `MEM_BLOCK`: store data.
- `done`  out  1: all `NUM_WORDS` stores accepted; sticky.
- `checksum`  out  64: running XOR of accepted store data (see Configuration).

## Operation
Counters:
- `in_cnt` counts words pushed; saturates at `NUM_WORDS`.
- `wr_cnt` counts stores accepted; saturates at `NUM_WORDS`.
- Both are wide enough to hold the value `NUM_WORDS`.

FIFO behaviour:
- Push when `in_valid && in_ready`.
- `in_ready = !full && (in_cnt < NUM_WORDS)`. Words offered after `NUM_WORDS` are never accepted; `in_ready` stays 0 until reset.
- `in_ready` is a registered-state function only. There is no combinational path from `mem_grant` or the tag.

Store issue:
- `proc2mem_command = MEM_STORE` when `mem_grant && !empty`; otherwise `MEM_NONE`.
- `proc2mem_addr = BASE_ADDR + 8*wr_cnt`, computed modulo 2^32. `proc2mem_data` = FIFO head. Both are held stable while un-accepted.
- The store is accepted when `proc2mem_command == MEM_STORE && mem2proc_transaction_tag != 0`. On acceptance the head is popped and `wr_cnt` increments.
- With a zero tag the same address and data are re-presented on the next granted cycle. Dropping the grant mid-retry only holds the state; nothing is lost.

Simultaneous events:
- Push and pop in the same cycle are both allowed, and occupancy is unchanged.
- The full check uses pre-edge occupancy, so a pop does not reopen `in_ready` until the next cycle.

State machine:
- `RUN`: entered on reset; pushes and stores proceed. Moves to `FIN` at the edge where `wr_cnt` becomes `NUM_WORDS`.
- `FIN`: `done = 1`, command forced to `MEM_NONE`, `in_ready = 0`. Remains in `FIN` until reset.

Reset:
- Reset mid-run drops all buffered words, clears the counters and `checksum`, and returns to `RUN`.
- Stores already accepted are not undone.

## Timing
Reset values:
- `in_ready` = 1.
- `proc2mem_command` = `MEM_NONE`, `proc2mem_addr` = `BASE_ADDR`, `proc2mem_data` = 0.
- `done` = 0, `checksum` = 0.

Latency:
- A word pushed at edge t into an empty FIFO is presented on the bus in the cycle after t, if granted.
- A sustained grant with nonzero tags gives 1 store per cycle.

`done` rises in the cycle following the edge that accepted the final store.

## Configuration
Macro `AURA_WB_CHECKSUM_EN`:
- Defined: `checksum` is a register cleared by reset. It XORs in `proc2mem_data` on every accepted store, giving a golden-compare signature without a memory dump.
- Undefined: `checksum` is tied to 0 and the register is not synthesized.

## Test plan
- **Single word.** `NUM_WORDS=1`, `BASE_ADDR=0x1000`. Push `0xDEADBEEF_00000001` with grant and tag=1 held. Required:
  - `MEM_STORE` to 0x1000 one cycle after the push.
  - `done`=1 on the next cycle.
  - With the macro, `checksum`=`0xDEADBEEF00000001`.
- **Streaming.** Push 512 words at full rate with grant and tag=1 held. Required:
  - Addresses `O_BASE`..`O_BASE+0xFF8`.
  - `done` in the cycle after the 512th store; memory holds the exact data.
- **Backpressure.** Grant=0 while pushing. Required:
  - `in_ready` falls after `FIFO_DEPTH`=8 words; no command issued.
  - Raising grant drains the words in order.
- **Retry.** Tag=0 for 3 granted cycles, then tag=2. Required:
  - Identical addr/data for 4 cycles.
  - `wr_cnt` advances only once.
- **Overflow.** Keep `in_valid` high after 512 pushes. Required: `in_ready`=0, no further stores, `done` sticky.
- **Mid-run reset.** Assert reset after 100 stores. Required:
  - Next store after reset targets `BASE_ADDR`.
  - `done`=0, `checksum`=0.
